// File: rtl/clkdiv_cfg_ctrl_if.sv
// Ratio-request handshake between a configuration source and clkdiv_cfg_ctrl.
// A request is accepted when req_valid & req_ready are both high at a rising edge.
interface clkdiv_cfg_ctrl_if #(
    parameter int unsigned DIV_W = 5
);
    logic             req_valid;
    logic [DIV_W-1:0] req_ratio;
    logic             req_ready;

    modport master (
        output req_valid,
        output req_ratio,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_ratio,
        output req_ready
    );
endinterface

// File: rtl/clkdiv_cfg_ctrl.sv
// Ratio-update sequencer for the generic clock divider.
// Waits for the divided clock's low phase, gates the divider enable, loads the new
// ratio and re-enables after a settle window so no runt high pulse is produced.
// Optional feature macro: CLKDIV_CFG_REJECT_BYPASS_EN (drops ratio 0/1 requests and
// pulses o_err instead of sequencing them).
module clkdiv_cfg_ctrl #(
    parameter int unsigned DIV_W         = 5,
    parameter int unsigned RESET_RATIO   = 2,
    parameter int unsigned GATE_CYCLES   = 2,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    clkdiv_cfg_ctrl_if.slave     req_bus,
    input  logic                 i_div_clk,
    output logic                 o_clk_en,
    output logic [DIV_W-1:0]     o_div_ratio,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout
`ifdef CLKDIV_CFG_REJECT_BYPASS_EN
    ,
    output logic                 o_err
`endif
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWaitLow = 3'd1;
    localparam logic [2:0] StGate    = 3'd2;
    localparam logic [2:0] StLoad    = 3'd3;
    localparam logic [2:0] StSettle  = 3'd4;
    localparam logic [2:0] StDone    = 3'd5;

    localparam int unsigned CntMaxGs = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES
                                                                     : SETTLE_CYCLES;
    localparam int unsigned CntMax   = (CntMaxGs > TIMEOUT) ? CntMaxGs : TIMEOUT;
    localparam int unsigned CntW     = $clog2(CntMax + 1);

    // Counter load values: the state exits on the cycle the counter reads zero.
    localparam logic [CntW-1:0] GateLoad    = CntW'(GATE_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLoad  = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0] hold_q, hold_d;
    logic [DIV_W-1:0] ratio_d;
    logic             clk_en_d;
    logic             done_d;
    logic             timeout_d;
    logic             accept;
`ifdef CLKDIV_CFG_REJECT_BYPASS_EN
    logic             err_d;
`endif

    assign req_bus.req_ready = (state_q == StIdle);
    assign o_busy            = (state_q != StIdle);
    assign accept            = req_bus.req_valid && (state_q == StIdle);

    // Next-state, counter and registered-output logic for the update sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        ratio_d   = o_div_ratio;
        clk_en_d  = o_clk_en;
        done_d    = 1'b0;
        timeout_d = o_timeout;
`ifdef CLKDIV_CFG_REJECT_BYPASS_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                clk_en_d = i_en;
                if (accept) begin
`ifdef CLKDIV_CFG_REJECT_BYPASS_EN
                    if (req_bus.req_ratio < DIV_W'(2)) begin
                        err_d = 1'b1;
                    end else begin
                        hold_d    = req_bus.req_ratio;
                        timeout_d = 1'b0;
                        cnt_d     = TimeoutLoad;
                        state_d   = StWaitLow;
                    end
`else
                    hold_d    = req_bus.req_ratio;
                    timeout_d = 1'b0;
                    cnt_d     = TimeoutLoad;
                    state_d   = StWaitLow;
`endif
                end
            end
            StWaitLow: begin
                clk_en_d = i_en;
                if (!i_div_clk || !o_clk_en || (cnt_q == '0)) begin
                    // Only a wait that ended on the counter alone counts as a timeout.
                    if (i_div_clk && o_clk_en) begin
                        timeout_d = 1'b1;
                    end
                    clk_en_d = 1'b0;
                    cnt_d    = GateLoad;
                    state_d  = StGate;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGate: begin
                clk_en_d = 1'b0;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StLoad: begin
                // Ratio and enable change on the same edge so the divider restarts cleanly.
                ratio_d  = hold_q;
                clk_en_d = i_en;
                cnt_d    = SettleLoad;
                state_d  = StSettle;
            end
            StSettle: begin
                clk_en_d = i_en;
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                clk_en_d = i_en;
                cnt_d    = '0;
                state_d  = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Sequencer state and registered outputs, asynchronously reset.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hold_q      <= DIV_W'(RESET_RATIO);
            o_div_ratio <= DIV_W'(RESET_RATIO);
            o_clk_en    <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            o_div_ratio <= ratio_d;
            o_clk_en    <= clk_en_d;
            o_done      <= done_d;
            o_timeout   <= timeout_d;
        end
    end

`ifdef CLKDIV_CFG_REJECT_BYPASS_EN
    // Rejection pulse for ratio 0/1 requests.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else begin
            o_err <= err_d;
        end
    end
`endif

endmodule

// File: doc/clkdiv_cfg_ctrl.md
# clkdiv_cfg_ctrl

Ratio-update sequencer for the generic clock divider. It accepts new divide-ratio requests over a valid/ready handshake and waits for the divided clock to reach its low phase. It then gates the divider enable, loads the new ratio and re-enables the divider after a settle window, so software or other control logic can retune the divider without producing a runt high pulse. It sits between the configuration source and the divider's `i_clk_en`/`i_div_ratio` inputs, in the `i_ref_clk` domain.

## Interface

**Parameters**
- `DIV_W`, 5: width of the divide ratio.
- `RESET_RATIO`, 2: value of `o_div_ratio` after reset.
- `GATE_CYCLES`, 2: cycles the enable is held low before the load; legal range ≥1.
- `SETTLE_CYCLES`, 4: cycles after re-enable before done; legal range ≥1.
- `TIMEOUT`, 64: maximum cycles spent waiting for the low phase.

**Ports**
- `i_ref_clk` in 1: reference clock; sole clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_en` in 1: requested divider enable.
- `i_req_valid` in 1: ratio request valid.
- `i_req_ratio` in `DIV_W`: requested ratio.
- `o_req_ready` in/out: out 1; request accepted when `i_req_valid & o_req_ready` at a rising edge.
- `i_div_clk` in 1: divider output fed back; a register in the same domain.
- `o_clk_en` out 1: to divider `i_clk_en`.
- `o_div_ratio` out `DIV_W`: to divider `i_div_ratio`.
- `o_busy` out 1: sequence in progress.
- `o_done` out 1: one-cycle pulse at sequence end.
- `o_timeout` out 1: sticky; the last sequence hit `TIMEOUT`.
- `o_err` out 1: one-cycle pulse on a rejected ratio; exists only when the macro is defined.

## Operation

- FSM states: IDLE, WAIT_LOW, GATE, LOAD, SETTLE, DONE. All outputs are registered except `o_req_ready` and `o_busy`.
  - `o_req_ready` = (state == IDLE).
  - `o_busy` = (state != IDLE).
- **IDLE**
  - `o_clk_en` <= `i_en`.
  - On accept: capture `i_req_ratio` into an internal holding register, clear `o_timeout`, go to WAIT_LOW.
- **WAIT_LOW**
  - `o_clk_en` keeps tracking `i_en`.
  - Leave for GATE when any of these holds: `i_div_clk == 0`, `o_clk_en == 0`, or the wait counter reaches `TIMEOUT-1`.
  - On the timeout exit, set `o_timeout`.
- **GATE**
  - `o_clk_en` <= 0 on entry.
  - Stay exactly `GATE_CYCLES` cycles, then go to LOAD.
- **LOAD**
  - Lasts one cycle with `o_clk_en` = 0.
  - On exit: `o_div_ratio` <= held ratio and `o_clk_en` <= `i_en`, both on the same edge.
- **SETTLE**
  - `o_clk_en` tracks `i_en`.
  - Stay exactly `SETTLE_CYCLES` cycles, then go to DONE.
- **DONE**
  - `o_done` = 1 for one cycle, then IDLE.
- A single down-counter, sized to max(`GATE_CYCLES`, `SETTLE_CYCLES`, `TIMEOUT`), is reloaded on every state entry.
- Requests presented while busy are not accepted. `i_req_ratio` is sampled only at accept, so later changes have no effect.
- A request with a ratio equal to the current `o_div_ratio` still runs the full sequence.

## Timing

- Reset (asynchronous, any state):
  - state = IDLE.
  - `o_div_ratio` = `RESET_RATIO`.
  - `o_clk_en` = 0.
  - `o_done`, `o_timeout`, `o_err` = 0.
  - `o_req_ready` = 1 and `o_busy` = 0.
- Reset asserted mid-sequence aborts it; the ratio reverts to `RESET_RATIO`.
- First rising edge after reset release: `o_clk_en` <= `i_en`.
- Sequence timing, with the accept at edge 0 and `i_div_clk` low at edge 1:
  - Edge 1: `o_clk_en` falls.
  - Edge 2+G: `o_div_ratio` updates and `o_clk_en` is restored.
  - Edge 2+G+S: `o_done` rises.
  - Edge 3+G+S: `o_req_ready` rises.
  - G = `GATE_CYCLES`, S = `SETTLE_CYCLES`.
- Each cycle `i_div_clk` stays high in WAIT_LOW adds one cycle, bounded by `TIMEOUT`.
- Back-to-back requests: the earliest possible next accept is the edge at which `o_req_ready` first reads 1.

## Configuration

- Macro: `CLKDIV_CFG_REJECT_BYPASS_EN`.
- **Defined**
  - A request with ratio 0 or 1 is accepted but dropped: state stays IDLE, `o_div_ratio` and `o_clk_en` are unaffected, and `o_err` pulses one cycle after the accept edge.
  - `o_err` port present.
- **Undefined**
  - Ratios 0 and 1 are sequenced like any other ratio.
  - No `o_err` port.

## Test plan

- Reset release with `i_en`=1 → `o_clk_en` = 1 after edge 1 and `o_div_ratio` = 2.
- Defaults; `i_div_clk`=0; request ratio 6 accepted at edge 0:
  - `o_clk_en` = 0 during edges 1–4.
  - `o_div_ratio` = 6 and `o_clk_en` = 1 from edge 4.
  - `o_done` pulse after edge 8.
  - `o_req_ready` = 1 after edge 9.
- `i_div_clk` held high for 10 cycles after accept → gating is delayed 10 cycles and `o_timeout` stays 0.
- `i_div_clk` stuck high → exit after 64 cycles, `o_timeout` = 1, and the next accept clears it.
- Assert `i_rst` while in SETTLE with ratio 9 loaded → immediately `o_div_ratio` = 2, `o_clk_en` = 0, `o_req_ready` = 1.
- With `CLKDIV_CFG_REJECT_BYPASS_EN` defined, request ratio 1 → one-cycle `o_err`, `o_busy` never 1, ratio unchanged.
